// File: rtl/move_key_repeater_if.sv
// rtl/move_key_repeater_if.sv - key event input and movement pulse output bundle
interface move_key_repeater_if;
   logic       key_valid;
   logic [8:0] key_code;
   logic       key_make;
   logic       A_signal;
   logic       D_signal;
   logic       W_signal;
   logic       S_signal;
   logic [3:0] held;

   modport master (
      output key_valid, key_code, key_make,
      input  A_signal, D_signal, W_signal, S_signal, held
   );

   modport slave (
      input  key_valid, key_code, key_make,
      output A_signal, D_signal, W_signal, S_signal, held
   );
endinterface

// File: rtl/move_key_repeater.sv
// rtl/move_key_repeater.sv - held-key tracker emitting rate-limited A/D/W/S step pulses
module move_key_repeater #(
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 1_000_000,
   parameter int CNT_W         = 25
) (
   input logic clk,
   input logic rst,
   move_key_repeater_if.slave bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DELAY  = 2'd1;
   localparam logic [1:0] REPEAT = 2'd2;

   logic [1:0]       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [3:0]       held, held_nx;
   logic [3:0]       pulse, pulse_nx;
   logic [3:0]       key_mask;
   logic             press;
   logic             expire;

   function automatic logic [3:0] pick(input logic [3:0] h);
      if (h[3])      return 4'b1000;
      else if (h[2]) return 4'b0100;
      else if (h[1]) return 4'b0010;
      else if (h[0]) return 4'b0001;
      else           return 4'b0000;
   endfunction

   // Bit order {A,D,W,S}; codes with the extended bit set fall through to zero.
   always_comb begin
      key_mask = 4'b0000;
      case (bus.key_code)
         9'h01C:  key_mask = 4'b1000;
         9'h023:  key_mask = 4'b0100;
         9'h01D:  key_mask = 4'b0010;
         9'h01B:  key_mask = 4'b0001;
         default: key_mask = 4'b0000;
      endcase
   end

   always_comb begin
      held_nx  = held;
      state_nx = state;
      cnt_nx   = cnt;
      pulse_nx = 4'b0000;
      press    = 1'b0;
      expire   = ((state == DELAY)  && (cnt == CNT_W'(REPEAT_DELAY - 1))) ||
                 ((state == REPEAT) && (cnt == CNT_W'(REPEAT_PERIOD - 1)));

      if (bus.key_valid && (key_mask != 4'b0000)) begin
         if (bus.key_make) begin
            press   = ((held & key_mask) == 4'b0000);
            held_nx = held | key_mask;
         end else begin
            held_nx = held & ~key_mask;
         end
      end

      // A fresh press outranks expiry; a final release outranks expiry.
      if (press) begin
         pulse_nx = pick(held_nx);
         cnt_nx   = '0;
         state_nx = DELAY;
      end else if (held_nx == 4'b0000) begin
         cnt_nx   = '0;
         state_nx = IDLE;
      end else if (expire) begin
         pulse_nx = pick(held_nx);
         cnt_nx   = '0;
         state_nx = REPEAT;
      end else if (state != IDLE) begin
         cnt_nx   = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         held  <= 4'b0000;
         pulse <= 4'b0000;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         held  <= held_nx;
         pulse <= pulse_nx;
      end
   end

   assign bus.A_signal = pulse[3];
   assign bus.D_signal = pulse[2];
   assign bus.W_signal = pulse[1];
   assign bus.S_signal = pulse[0];
   assign bus.held     = held;
endmodule

// File: tb/tb_move_key_repeater.sv
// tb/tb_move_key_repeater.sv - randomized bench against a pulse-schedule model
module tb_move_key_repeater;
   localparam int RD = 8;
   localparam int RP = 4;

   localparam logic [8:0] K_A = 9'h01C;
   localparam logic [8:0] K_D = 9'h023;
   localparam logic [8:0] K_W = 9'h01D;
   localparam logic [8:0] K_S = 9'h01B;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   move_key_repeater_if bus();

   move_key_repeater #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model: held set plus the absolute edge index of the next scheduled pulse.
   logic [3:0] m_held  = 4'b0000;
   logic [3:0] m_pulse = 4'b0000;
   int         next_fire = -1;
   int         cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @edge %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [3:0] mask_of(input logic [8:0] c);
      if (c == K_A)      return 4'b1000;
      else if (c == K_D) return 4'b0100;
      else if (c == K_W) return 4'b0010;
      else if (c == K_S) return 4'b0001;
      else               return 4'b0000;
   endfunction

   function automatic logic [3:0] leader(input logic [3:0] h);
      for (int i = 3; i >= 0; i--)
         if (h[i]) return 4'b0001 << i;
      return 4'b0000;
   endfunction

   task automatic model_edge(input logic v, input logic [8:0] c, input logic m);
      logic [3:0] mk;
      logic [3:0] nh;
      mk = mask_of(c);
      nh = m_held;
      m_pulse = 4'b0000;
      if (v && mk != 4'b0000) nh = m ? (m_held | mk) : (m_held & ~mk);
      if (v && m && mk != 4'b0000 && (m_held & mk) == 4'b0000) begin
         m_pulse   = leader(nh);
         next_fire = cyc + RD;
      end else if (nh == 4'b0000) begin
         next_fire = -1;
      end else if (cyc == next_fire) begin
         m_pulse   = leader(nh);
         next_fire = cyc + RP;
      end
      m_held = nh;
   endtask

   // Called at a negedge; drives one cycle of input and checks the result.
   task automatic step(input logic v, input logic [8:0] c, input logic m);
      logic [3:0] p;
      bus.key_valid = v;
      bus.key_code  = c;
      bus.key_make  = m;
      @(posedge clk);
      model_edge(v, c, m);
      #1;
      p = {bus.A_signal, bus.D_signal, bus.W_signal, bus.S_signal};
      check("held", 32'(bus.held), 32'(m_held));
      check("pulse", 32'(p), 32'(m_pulse));
      check("onehot", 32'($onehot0(p)), 32'd1);
      cyc++;
      @(negedge clk);
      bus.key_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 9'h000, 1'b0);
   endtask

   task automatic release_all();
      step(1'b1, K_A, 1'b0);
      step(1'b1, K_D, 1'b0);
      step(1'b1, K_W, 1'b0);
      step(1'b1, K_S, 1'b0);
      idle(2);
   endtask

   logic [8:0] pool [7];

   initial begin
      logic [3:0] p;
      pool[0] = K_A; pool[1] = K_D; pool[2] = K_W; pool[3] = K_S;
      pool[4] = 9'h11C; pool[5] = 9'h029; pool[6] = 9'h11D;

      bus.key_valid = 1'b0;
      bus.key_code  = 9'h000;
      bus.key_make  = 1'b0;
      repeat (2) @(negedge clk);
      p = {bus.A_signal, bus.D_signal, bus.W_signal, bus.S_signal};
      check("rst_held", 32'(bus.held), 32'd0);
      check("rst_pulse", 32'(p), 32'd0);
      rst = 1'b0;

      // Single press, break at 20
      step(1'b1, K_A, 1'b1);
      idle(19);
      step(1'b1, K_A, 1'b0);
      idle(6);

      // Typematic re-makes leave the schedule alone
      step(1'b1, K_W, 1'b1);
      idle(2);
      step(1'b1, K_W, 1'b1);
      idle(6);
      step(1'b1, K_W, 1'b1);
      idle(8);
      release_all();

      // Priority: D held, A pressed then released
      step(1'b1, K_D, 1'b1);
      idle(4);
      step(1'b1, K_A, 1'b1);
      idle(9);
      step(1'b1, K_A, 1'b0);
      idle(8);
      release_all();

      // Press coinciding with expiry
      step(1'b1, K_S, 1'b1);
      idle(7);
      step(1'b1, K_W, 1'b1);
      idle(10);
      release_all();

      // Untracked and extended codes
      step(1'b1, 9'h11C, 1'b1);
      step(1'b1, 9'h029, 1'b1);
      idle(10);

      // Asynchronous reset while a pulse and held bit are live
      step(1'b1, K_A, 1'b1);
      #2 rst = 1'b1;
      #1;
      p = {bus.A_signal, bus.D_signal, bus.W_signal, bus.S_signal};
      check("async_rst_held", 32'(bus.held), 32'd0);
      check("async_rst_pulse", 32'(p), 32'd0);
      m_held = 4'b0000;
      next_fire = -1;
      @(negedge clk);
      rst = 1'b0;
      idle(20);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) == 0)
            step(1'b1, pool[$urandom_range(0, 6)], ($urandom_range(0, 9) < 6));
         else
            idle(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/move_key_repeater.md
# move_key_repeater

Converts PS/2 key events from the keyboard decoder into rate-limited, one-cycle A/D/W/S movement pulses for the sprite position controller. It tracks which movement keys are held and emits one step immediately on a press. While a key stays held, it first waits a delay, then repeats at a fixed period. At most one direction pulse is asserted per cycle, using the same A > D > W > S priority that the position controller applies.

## Interface
- REPEAT_DELAY, 25_000_000: clk cycles from press pulse to first auto-repeat pulse; must be ≥ 2
- REPEAT_PERIOD, 1_000_000: clk cycles between auto-repeat pulses; must be ≥ 2
- CNT_W, 25: counter width; must hold max(REPEAT_DELAY, REPEAT_PERIOD) − 1
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle strobe; key_code/key_make are valid this cycle
- key_code  in  9  {extended bit, scan code}; tracked codes: A=9'h01C, D=9'h023, W=9'h01D, S=9'h01B
- key_make  in  1  1 = make (press), 0 = break (release)
- A_signal  out  1  one-cycle step pulse, A direction
- D_signal  out  1  one-cycle step pulse, D direction
- W_signal  out  1  one-cycle step pulse, W direction
- S_signal  out  1  one-cycle step pulse, S direction
- held  out  4  registered held flags {A,D,W,S}, bit 3 = A

## Operation
- Held tracking:
  - A key_valid with a tracked code sets its held bit when key_make=1 and clears it when key_make=0.
  - Untracked codes are ignored. Extended-bit-set codes are untracked.
- Active key: the highest-priority set held bit, in order A > D > W > S.
- FSM states:
  - IDLE: no key held.
  - DELAY: counting up to the first repeat.
  - REPEAT: counting the repeat period.
- Press event: a make of a tracked key whose held bit is currently 0.
  - Emit one pulse for the active key, computed after the held update. This pulses A, not D, if A is already held when D is pressed.
  - Clear cnt to 0 and enter DELAY, from any state.
- Typematic re-makes (make of an already-held key) do nothing. Counter and state are unaffected.
- DELAY: cnt increments each cycle. When cnt = REPEAT_DELAY−1, emit a pulse for the active key, clear cnt and enter REPEAT.
- REPEAT: when cnt = REPEAT_PERIOD−1, emit a pulse for the active key and clear cnt.
- Break event:
  - If it clears the last held bit: go to IDLE, clear cnt, emit no pulse in that cycle.
  - Otherwise: state and cnt continue unchanged. The active key is re-evaluated, so later pulses go to the new active key.
- Simultaneous events at one edge:
  - Press event together with timer expiry: the press wins. One pulse is emitted and the counter restarts in DELAY. Never two pulses.
  - Non-final break together with timer expiry: the pulse goes to the new active key after the release.
  - Final break together with timer expiry: no pulse, go to IDLE.
- Outputs A/D/W/S are mutually exclusive (one-hot or zero) in every cycle.
- Reset: held=0, cnt=0, state=IDLE, all pulses 0, all asynchronous. Reset asserted mid-hold drops everything. After release, keys must be pressed again (new make) to move.

## Timing
- All outputs are registered.
- A press event sampled at rising edge k produces a pulse high from edge k to edge k+1. held reflects the press in the same cycle.
- First auto-repeat pulse: edge k+REPEAT_DELAY to k+REPEAT_DELAY+1.
- Subsequent pulses: every REPEAT_PERIOD edges after that.
- A break sampled at edge j: held is cleared from edge j. No pulse is produced for the released key at or after edge j.
- cnt is CNT_W bits and never wraps; it is cleared on every expiry and on every press event.

## Test plan
Parameters for all scenarios: REPEAT_DELAY=8, REPEAT_PERIOD=4.
- Reset: assert rst mid-count with held=4'b1000 → all outputs 0 and held=0 immediately, without waiting for a clock edge; after release, no pulses until a new make arrives.
- Single press: make 9'h01C at edge 0, break at edge 20 → A_signal high in cycles 0, 8, 12, 16; nothing from 20 on; held[3] high in cycles 0–19.
- Typematic: make W at edge 0, re-make W at edges 3 and 10 → W pulses only at 0, 8, 12, 16…; the schedule is unchanged.
- Priority: hold D (make at edge 0); make A at edge 5; break A at edge 15 → D at 0; A at 5, 13; D at 17, 21.
- Collision: make S at edge 0, make W at edge 8 (coincides with expiry) → exactly one pulse at 8 (W_signal); next pulse at 16.
- Untracked and extended codes: make 9'h11C and 9'h029 → held stays 0 and no pulses occur.
